// File: rtl/wrf_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : wrf_tx_arbiter                                                 |
// | Purpose : Round-robin scheduler sharing one WR fabric TX port between    |
// |           N_SRC frame generators. Grants one source at a time, pulses    |
// |           its send strobe, muxes its 16-bit valid/ready stream onto the  |
// |           fabric, closes the frame after FRAME_WORDS accepted words,     |
// |           inserts an inter-frame gap and aborts stalled frames.          |
// | Ports   : wrf_clk/wrf_rst   clock, async active-high reset               |
// |           src_req/src_send  per-source request level / start pulse       |
// |           src_valid/src_data/src_ready  per-source stream                |
// |           wrf_valid/wrf_data/wrf_ready  fabric stream                    |
// |           busy, grant_idx, frame_cnt, err_timeout  status                |
// | Config  : `define WRF_TX_ARB_STATS_EN enables the frame counter and an   |
// |           internal 8-bit saturating abort counter (abort_cnt_q).         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module wrf_tx_arbiter #(
  parameter int N_SRC       = 2,
  parameter int FRAME_WORDS = 127,
  parameter int GAP_CYCLES  = 8,
  parameter int TIMEOUT     = 1023,
  localparam int GW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                wrf_clk,
  input  logic                wrf_rst,
  input  logic [N_SRC-1:0]    src_req,
  output logic [N_SRC-1:0]    src_send,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [16*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]    src_ready,
  output logic                wrf_valid,
  output logic [15:0]         wrf_data,
  input  logic                wrf_ready,
  output logic                busy,
  output logic [GW-1:0]       grant_idx,
  output logic [15:0]         frame_cnt,
  output logic                err_timeout
);

  localparam int WCW = ($clog2(FRAME_WORDS) > 7) ? $clog2(FRAME_WORDS) : 7;
  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GCW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
  localparam logic [TCW-1:0] LAST_IDLE = TCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] LAST_GAP  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_XFER       = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [N_SRC-1:0] send_q, send_d;
  logic [WCW-1:0]   word_q, word_d;
  logic [TCW-1:0]   idle_q, idle_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic             err_q, err_d;
  logic             frame_done;

  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic [N_SRC-1:0] pick_oh;
  logic             mux_open;
  logic             sel_valid;
  logic [15:0]      sel_data;
  logic             accept;

  // Round-robin search starting at ptr+1. Offsets are scanned from farthest
  // to nearest so the nearest requester is the last (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      for (int i = 0; i < N_SRC; i++) begin
        if ((i == ((int'(ptr_q) + k) % N_SRC)) && src_req[i]) begin
          pick_found = 1'b1;
          pick_idx   = GW'(i);
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  // Stream mux: open while waiting for or transferring the granted frame.
  assign mux_open = (state_q == S_WAIT_VALID) || (state_q == S_XFER);

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[16*i +: 16];
        if (mux_open) begin
          src_ready[i] = wrf_ready;
        end
      end
    end
  end

  assign wrf_valid = mux_open & sel_valid;
  assign wrf_data  = wrf_valid ? sel_data : 16'h0000;
  assign accept    = wrf_valid & wrf_ready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    send_d     = '0;
    word_d     = word_q;
    idle_d     = idle_q;
    gap_d      = gap_q;
    err_d      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          send_d  = pick_oh;
          state_d = S_START;
        end
      end
      S_START: begin
        word_d  = '0;
        idle_d  = '0;
        state_d = S_WAIT_VALID;
      end
      S_WAIT_VALID, S_XFER: begin
        if (sel_valid) begin
          state_d = S_XFER;
        end
        // An accepted word clears the idle counter, so completion always
        // takes precedence over a coincident timeout.
        if (accept) begin
          idle_d = '0;
          if (word_q == LAST_WORD) begin
            frame_done = 1'b1;
            gap_d      = '0;
            state_d    = S_GAP;
          end else begin
            word_d = word_q + 1'b1;
          end
        end else if (idle_q == LAST_IDLE) begin
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_GAP: begin
        // GAP_CYCLES of 0 still spends one transit cycle here.
        if (gap_q >= LAST_GAP) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wrf_clk or posedge wrf_rst) begin
    if (wrf_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(N_SRC - 1);
      send_q  <= '0;
      word_q  <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      send_q  <= send_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

`ifdef WRF_TX_ARB_STATS_EN
  logic [15:0] frame_q;
  logic [7:0]  abort_cnt_q;

  always_ff @(posedge wrf_clk or posedge wrf_rst) begin
    if (wrf_rst) begin
      frame_q     <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (frame_done) begin
        frame_q <= frame_q + 16'd1;
      end
      if (err_d && (abort_cnt_q != 8'hFF)) begin
        abort_cnt_q <= abort_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign frame_cnt         = 16'h0000;
`endif

  assign src_send    = send_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_idx   = grant_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wrf_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_wrf_tx_arbiter                                              |
// | Purpose : Self-checking bench for wrf_tx_arbiter (N_SRC=2). Source       |
// |           models stream numbered words after their send pulse; expected  |
// |           words are queued at the send pulse and popped on acceptance.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_wrf_tx_arbiter;

  localparam int N  = 2;
  localparam int FW = 127;

  logic          wrf_clk = 1'b0;
  logic          wrf_rst;
  logic [N-1:0]  src_req;
  logic [N-1:0]  src_send;
  logic [N-1:0]  src_valid;
  logic [16*N-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          wrf_valid;
  logic [15:0]   wrf_data;
  logic          wrf_ready;
  logic          busy;
  logic [0:0]    grant_idx;
  logic [15:0]   frame_cnt;
  logic          err_timeout;

  wrf_tx_arbiter dut (
    .wrf_clk     (wrf_clk),
    .wrf_rst     (wrf_rst),
    .src_req     (src_req),
    .src_send    (src_send),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .wrf_valid   (wrf_valid),
    .wrf_data    (wrf_data),
    .wrf_ready   (wrf_ready),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .frame_cnt   (frame_cnt),
    .err_timeout (err_timeout)
  );

  always #5 wrf_clk = ~wrf_clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          act[N];
  int          idx[N];
  int          cur_g = 0;
  bit          silent = 1'b0;
  bit          rdy_toggle = 1'b0;
  int          exp_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fexp(input int n);
`ifdef WRF_TX_ARB_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n) * 32'd0;
`endif
  endfunction

  // Source models and fabric-side scoreboard.
  initial begin
    src_valid = '0;
    src_data  = '0;
    wrf_ready = 1'b1;
    forever begin
      @(negedge wrf_clk);
      if (wrf_rst) begin
        for (int i = 0; i < N; i++) begin
          act[i] = 1'b0;
          idx[i] = 0;
        end
        exp_q.delete();
      end else begin
        if (wrf_valid && wrf_ready) begin
          if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
          else check("wrf_data", 32'(wrf_data), 32'(exp_q.pop_front()));
        end
        if (!wrf_valid) begin
          check("idle_data", 32'(wrf_data), 32'd0);
        end else begin
          for (int i = 0; i < N; i++)
            check("src_ready", 32'(src_ready[i]), (i == cur_g) ? 32'(wrf_ready) : 32'd0);
        end
        for (int i = 0; i < N; i++) begin
          if (act[i] && src_valid[i] && src_ready[i]) begin
            idx[i]++;
            if (idx[i] == FW) act[i] = 1'b0;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (src_send[i]) begin
            cur_g = i;
            if (!silent) begin
              act[i] = 1'b1;
              idx[i] = 0;
              for (int k = 0; k < FW; k++) exp_q.push_back(16'(i * 4096 + k));
            end
          end
        end
      end
      @(posedge wrf_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        src_valid[i]         = act[i];
        src_data[16*i +: 16] = 16'(i * 4096 + idx[i]);
      end
      wrf_ready = rdy_toggle ? ~wrf_ready : 1'b1;
    end
  end

  task automatic wait_send(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge wrf_clk);
      n++;
      if (src_send != '0) break;
    end
    if (src_send == '0) check("send_wait_expired", 32'd0, 32'd1);
  endtask

  // Follows a granted frame from WAIT_VALID until the arbiter returns to IDLE.
  task automatic run_frame(output int words, output int gap, output int sends, output int errs);
    int budget;
    words = 0; gap = 0; sends = 0; errs = 0; budget = 0;
    while (budget < 5000) begin
      @(negedge wrf_clk);
      budget++;
      if (!busy) break;
      if (src_send != '0) sends++;
      if (err_timeout) errs++;
      if (wrf_valid && wrf_ready) begin
        words++;
        gap = 0;
      end else begin
        gap++;
      end
    end
    if (busy) check("frame_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int n, words, gap, sends, errs, g;
    wrf_rst = 1'b1;
    src_req = '0;
    repeat (3) @(negedge wrf_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(wrf_valid), 32'd0);
    check("rst_send", 32'(src_send), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_frames", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    @(posedge wrf_clk); #1 wrf_rst = 1'b0;

    // Single requester, full frame, gap length.
    @(posedge wrf_clk); #1 src_req = 2'b01;
    wait_send(n);
    check("s1_send_lat", 32'(n), 32'd2);
    check("s1_send", 32'(src_send), 32'b01);
    check("s1_grant", 32'(grant_idx), 32'd0);
    check("s1_busy", 32'(busy), 32'd1);
    src_req = '0;
    run_frame(words, gap, sends, errs);
    exp_frames++;
    check("s1_words", 32'(words), 32'(FW));
    check("s1_gap", 32'(gap), 32'd8);
    check("s1_send_once", 32'(sends), 32'd0);
    check("s1_err", 32'(errs), 32'd0);
    check("s1_frames", 32'(frame_cnt), fexp(exp_frames));
    check("s1_sb_left", 32'(exp_q.size()), 32'd0);

    // Both requesting: grants alternate starting with source 1.
    src_req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      g = (f % 2 == 0) ? 1 : 0;
      wait_send(n);
      check("s2_grant", 32'(grant_idx), 32'(g));
      check("s2_send", 32'(src_send), 32'(1 << g));
      run_frame(words, gap, sends, errs);
      exp_frames++;
      check("s2_words", 32'(words), 32'(FW));
    end
    src_req = '0;
    check("s2_frames", 32'(frame_cnt), fexp(exp_frames));

    // Fabric ready toggling every cycle.
    rdy_toggle = 1'b1;
    src_req = 2'b01;
    wait_send(n);
    check("s3_grant", 32'(grant_idx), 32'd0);
    src_req = '0;
    run_frame(words, gap, sends, errs);
    exp_frames++;
    rdy_toggle = 1'b0;
    check("s3_words", 32'(words), 32'(FW));
    check("s3_gap", 32'(gap), 32'd8);
    check("s3_frames", 32'(frame_cnt), fexp(exp_frames));

    // Granted source stays silent: timeout abort.
    silent = 1'b1;
    src_req = 2'b10;
    wait_send(n);
    check("s4_grant", 32'(grant_idx), 32'd1);
    src_req = '0;
    n = 0;
    while (n < 1100) begin
      @(negedge wrf_clk);
      if (err_timeout) break;
      n++;
    end
    check("s4_timeout_cycle", 32'(n), 32'd1023);
    @(negedge wrf_clk);
    check("s4_err_pulse", 32'(err_timeout), 32'd0);
    gap = 1;
    while (busy && gap < 100) begin
      gap++;
      @(negedge wrf_clk);
    end
    check("s4_gap", 32'(gap), 32'd8);
    check("s4_frames", 32'(frame_cnt), fexp(exp_frames));
    check("s4_sb_left", 32'(exp_q.size()), 32'd0);
    silent = 1'b0;
    src_req = 2'b01;
    wait_send(n);
    check("s4_next_grant", 32'(grant_idx), 32'd0);
    src_req = '0;
    run_frame(words, gap, sends, errs);
    exp_frames++;
    check("s4_next_words", 32'(words), 32'(FW));

    // Reset after word 50 of a frame.
    src_req = 2'b01;
    wait_send(n);
    src_req = '0;
    n = 0;
    for (int c = 0; c < 500 && n < 50; c++) begin
      @(negedge wrf_clk);
      if (wrf_valid && wrf_ready) n++;
    end
    @(posedge wrf_clk);
    #2 wrf_rst = 1'b1;
    #1;
    check("s5_valid", 32'(wrf_valid), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_ready", 32'(src_ready), 32'd0);
    check("s5_err", 32'(err_timeout), 32'd0);
    check("s5_frames", 32'(frame_cnt), 32'd0);
    exp_frames = 0;
    repeat (2) @(posedge wrf_clk);
    #1 wrf_rst = 1'b0;
    src_req = 2'b10;
    wait_send(n);
    check("s5_grant", 32'(grant_idx), 32'd1);
    check("s5_send", 32'(src_send), 32'b10);
    src_req = '0;
    run_frame(words, gap, sends, errs);
    exp_frames++;
    check("s5_words", 32'(words), 32'(FW));
    check("s5_frames_after", 32'(frame_cnt), fexp(exp_frames));

    // After reset, source 0 wins when both request.
    @(posedge wrf_clk); #1 wrf_rst = 1'b1;
    @(posedge wrf_clk); #1 wrf_rst = 1'b0;
    exp_frames = 0;
    src_req = 2'b11;
    wait_send(n);
    check("s6_grant", 32'(grant_idx), 32'd0);
    src_req = '0;
    run_frame(words, gap, sends, errs);
    exp_frames++;
    check("s6_words", 32'(words), 32'(FW));
    check("s6_frames", 32'(frame_cnt), fexp(exp_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
